// File: rtl/bitcoin2.sv
// Double-SHA-256 nonce search co-processor: reads a 19-word header prefix, hashes it for
// nonces 0..NUM_NONCES-1 with one shared compression engine, and writes digest word H0 back.
module bitcoin2 #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] message_addr,
    input  logic [15:0] output_addr,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {IDLE, READ, BLK1, BLK2, HASH2, WRITE, DONE} state_t;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    state_t      state;
    logic [4:0]  rcnt;
    logic [6:0]  rnd;
    logic [31:0] nonce;
    logic [15:0] msg_base;
    logic [15:0] out_base;

    logic [31:0] m     [19];
    logic [31:0] st    [8];
    logic [31:0] hinit [8];
    logic [31:0] mid   [8];
    logic [31:0] w     [16];

    logic [31:0] t1, t2, w_new, nonce_sel;
    logic [31:0] sum  [8];
    logic [31:0] blk2 [16];
    logic        last;

    assign mem_clk = clk;
    assign last    = (rnd == 7'd64);

    always_comb begin
        t1    = st[7] + bsig1(st[4]) + ((st[4] & st[5]) ^ (~st[4] & st[6])) + K[rnd[5:0]] + w[0];
        t2    = bsig0(st[0]) + ((st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]));
        w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
        for (int i = 0; i < 8; i++) sum[i] = hinit[i] + st[i];
        // WRITE preloads the block for the following nonce
        nonce_sel = (state == WRITE) ? nonce + 32'd1 : nonce;
        for (int j = 0; j < 16; j++) blk2[j] = 32'h0;
        blk2[0]  = m[16];
        blk2[1]  = m[17];
        blk2[2]  = m[18];
        blk2[3]  = nonce_sel;
        blk2[4]  = 32'h80000000;
        blk2[15] = 32'h00000280;
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state          <= IDLE;
            done           <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= 16'h0;
            mem_write_data <= 32'h0;
            nonce          <= 32'h0;
            rcnt           <= 5'd0;
            rnd            <= 7'd0;
            msg_base       <= 16'h0;
            out_base       <= 16'h0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= READ;
                        done     <= 1'b0;
                        msg_base <= message_addr;
                        out_base <= output_addr;
                        mem_addr <= message_addr;
                        rcnt     <= 5'd0;
                        nonce    <= 32'h0;
                    end
                end
                READ: begin
                    rcnt <= rcnt + 5'd1;
                    if (rcnt < 5'd18) mem_addr <= msg_base + {11'd0, rcnt} + 16'd1;
                    if (rcnt == 5'd19) begin
                        state <= BLK1;
                        rnd   <= 7'd0;
                    end
                end
                BLK1, BLK2: begin
                    if (last) begin
                        rnd   <= 7'd0;
                        state <= (state == BLK1) ? BLK2 : HASH2;
                    end else begin
                        rnd <= rnd + 7'd1;
                    end
                end
                HASH2: begin
                    if (last) begin
                        rnd            <= 7'd0;
                        state          <= WRITE;
                        mem_we         <= 1'b1;
                        mem_addr       <= out_base + nonce[15:0];
                        mem_write_data <= sum[0];
                    end else begin
                        rnd <= rnd + 7'd1;
                    end
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    if (nonce < 32'(NUM_NONCES - 1)) begin
                        nonce <= nonce + 32'd1;
                        state <= BLK2;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: header capture, round engine, and per-block initial hash loading
    always_ff @(posedge clk) begin
        case (state)
            READ: begin
                if (rcnt != 5'd0) m[rcnt - 5'd1] <= mem_read_data;
                if (rcnt == 5'd19) begin
                    for (int i = 0; i < 8; i++) begin
                        st[i]    <= IV[i];
                        hinit[i] <= IV[i];
                    end
                    for (int j = 0; j < 16; j++) w[j] <= m[j];
                end
            end
            BLK1, BLK2, HASH2: begin
                if (!last) begin
                    st[0] <= t1 + t2;
                    st[1] <= st[0];
                    st[2] <= st[1];
                    st[3] <= st[2];
                    st[4] <= st[3] + t1;
                    st[5] <= st[4];
                    st[6] <= st[5];
                    st[7] <= st[6];
                    for (int j = 0; j < 15; j++) w[j] <= w[j + 1];
                    w[15] <= w_new;
                end else if (state == BLK1) begin
                    for (int i = 0; i < 8; i++) begin
                        mid[i]   <= sum[i];
                        st[i]    <= sum[i];
                        hinit[i] <= sum[i];
                    end
                    for (int j = 0; j < 16; j++) w[j] <= blk2[j];
                end else if (state == BLK2) begin
                    for (int i = 0; i < 8; i++) begin
                        st[i]    <= IV[i];
                        hinit[i] <= IV[i];
                        w[i]     <= sum[i];
                    end
                    w[8] <= 32'h80000000;
                    for (int j = 9; j < 15; j++) w[j] <= 32'h0;
                    w[15] <= 32'h00000100;
                end
            end
            WRITE: begin
                for (int i = 0; i < 8; i++) begin
                    st[i]    <= mid[i];
                    hinit[i] <= mid[i];
                end
                for (int j = 0; j < 16; j++) w[j] <= blk2[j];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bitcoin2.sv
// Bench for bitcoin2: independent SHA-256 reference model, write scoreboard, and
// scenario tasks for reset, golden run, alternate addresses, mid-run reset, restart, NUM_NONCES=4.
module tb_bitcoin2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start, start4;
    logic [15:0] message_addr, output_addr, msg4, out4;
    logic        done, mem_clk, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data, mem_read_data;
    logic        done4, mem_clk4, we4;
    logic [15:0] addr4;
    logic [31:0] wd4, rd4;

    logic [31:0] mem  [0:65535];
    logic [31:0] mem4 [0:1023];

    bitcoin2 #(.NUM_NONCES(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .message_addr(message_addr), .output_addr(output_addr),
        .done(done), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    bitcoin2 #(.NUM_NONCES(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4),
        .message_addr(msg4), .output_addr(out4),
        .done(done4), .mem_clk(mem_clk4), .mem_we(we4), .mem_addr(addr4),
        .mem_write_data(wd4), .mem_read_data(rd4)
    );

    always @(posedge mem_clk) begin
        if (mem_we) mem[mem_addr] <= mem_write_data;
        mem_read_data <= mem[mem_addr];
    end

    always @(posedge mem_clk4) begin
        if (we4) mem4[addr4[9:0]] <= wd4;
        rd4 <= mem4[addr4[9:0]];
    end

    localparam logic [31:0] KM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IVM = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] W [64];
        logic [31:0] a, b, c, d, e, f, g, h, x1, x2;
        for (int t = 0; t < 16; t++) W[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            W[t] = (rr(W[t-2], 17) ^ rr(W[t-2], 19) ^ (W[t-2] >> 10)) + W[t-7]
                 + (rr(W[t-15], 7) ^ rr(W[t-15], 18) ^ (W[t-15] >> 3)) + W[t-16];
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            x1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KM[t] + W[t];
            x2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + x1; d = c; c = b; b = a; a = x1 + x2;
        end
        return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
                e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
    endfunction

    logic [31:0] hdr [19];

    function automatic logic [31:0] model_h0(input logic [31:0] n);
        logic [511:0] b1, b2, b3;
        logic [255:0] md, h1, h2;
        for (int i = 0; i < 16; i++) b1[511 - 32*i -: 32] = hdr[i];
        md = compress(IVM, b1);
        b2 = {hdr[16], hdr[17], hdr[18], n, 32'h80000000, 320'h0, 32'h00000280};
        h1 = compress(md, b2);
        b3 = {h1, 32'h80000000, 192'h0, 32'h00000100};
        h2 = compress(IVM, b3);
        return h2[255:224];
    endfunction

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t exp4_q[$];
    wr_t mon_e, mon4_e;
    int  total = 0;
    int  bad = 0;
    int  wr_count = 0;
    int  wr4_count = 0;

    // Scoreboard: every write is popped against the next expected result
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_count++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write got addr=%0d data=%h want no write", mem_addr, mem_write_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_addr !== mon_e.addr || mem_write_data !== mon_e.data) begin
                    bad++;
                    $display("FAIL write_result got addr=%0d data=%h want addr=%0d data=%h",
                             mem_addr, mem_write_data, mon_e.addr, mon_e.data);
                end
            end
        end
        if (we4 === 1'b1) begin
            wr4_count++;
            total++;
            if (exp4_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write4 got addr=%0d data=%h want no write", addr4, wd4);
            end else begin
                mon4_e = exp4_q.pop_front();
                if (addr4 !== mon4_e.addr || wd4 !== mon4_e.data) begin
                    bad++;
                    $display("FAIL write_result4 got addr=%0d data=%h want addr=%0d data=%h",
                             addr4, wd4, mon4_e.addr, mon4_e.data);
                end
            end
        end
    end

    task automatic set_header(input logic [31:0] seed);
        hdr[0] = seed;
        for (int i = 1; i < 19; i++) hdr[i] = {hdr[i-1][30:0], hdr[i-1][31]};
    endtask

    task automatic load_and_expect(input logic [31:0] seed, input logic [15:0] mbase,
                                   input logic [15:0] obase);
        set_header(seed);
        for (int i = 0; i < 19; i++) mem[mbase + 16'(i)] = hdr[i];
        for (int n = 0; n < 16; n++) exp_q.push_back({obase + 16'(n), model_h0(32'(n))});
    endtask

    task automatic wait_done(input int bound, input string tag);
        int cyc;
        cyc = 0;
        while (done !== 1'b1 && cyc < bound + 200) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (done !== 1'b1 || cyc > bound) begin
            bad++;
            $display("FAIL %s_latency got %0d cycles done=%b want done=1 within %0d", tag, cyc, done, bound);
        end
    endtask

    task automatic test_model;
        logic [255:0] d;
        d = compress(IVM, {32'h61626380, 448'h0, 32'h00000018});
        total++;
        if (d[255:224] !== 32'hba7816bf) begin
            bad++;
            $display("FAIL model_abc got %h want ba7816bf", d[255:224]);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total += 4;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
        if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got %b want 0", mem_we); end
        if (mem_addr !== 16'h0) begin bad++; $display("FAIL reset_addr got %h want 0", mem_addr); end
        if (mem_write_data !== 32'h0) begin bad++; $display("FAIL reset_wdata got %h want 0", mem_write_data); end
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (done !== 1'b0 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL idle_quiet got done=%b we=%b want 0 0", done, mem_we);
        end
    endtask

    task automatic test_golden;
        int base_wr, diffs;
        load_and_expect(32'h01234567, 16'd0, 16'd1000);
        total++;
        if (hdr[1] !== 32'h02468ace) begin bad++; $display("FAIL header_gen got %h want 02468ace", hdr[1]); end
        base_wr = wr_count;
        message_addr = 16'd0; output_addr = 16'd1000;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(2199, "golden");
        total += 2;
        if (wr_count - base_wr !== 16) begin bad++; $display("FAIL golden_writes got %0d want 16", wr_count - base_wr); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL golden_pending got %0d want 0", exp_q.size()); end
        for (int n = 0; n < 16; n++) begin
            total++;
            if (mem[1000 + n] !== model_h0(32'(n))) begin
                bad++;
                $display("FAIL golden_mem[%0d] got %h want %h", 1000 + n, mem[1000 + n], model_h0(32'(n)));
            end
        end
        diffs = 0;
        for (int i = 0; i < 19; i++) if (mem[i] !== hdr[i]) diffs++;
        total++;
        if (diffs != 0) begin bad++; $display("FAIL header_intact got %0d changed words want 0", diffs); end
    endtask

    task automatic test_alt_addr;
        int base_wr;
        load_and_expect(32'hdeadbeef, 16'd100, 16'd2000);
        base_wr = wr_count;
        message_addr = 16'd100; output_addr = 16'd2000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        message_addr = 16'd7; output_addr = 16'd9;
        wait_done(2201, "alt");
        total += 2;
        if (wr_count - base_wr !== 16) begin bad++; $display("FAIL alt_writes got %0d want 16", wr_count - base_wr); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL alt_pending got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_midrun;
        int seen, cyc, base_wr;
        load_and_expect(32'h13579bdf, 16'd300, 16'd3000);
        message_addr = 16'd300; output_addr = 16'd3000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0; cyc = 0;
        while (seen < 5 && cyc < 1500) begin
            @(negedge clk);
            cyc++;
            if (mem_we === 1'b1) seen++;
        end
        total++;
        if (seen != 5) begin bad++; $display("FAIL midrun_reach got %0d writes want 5", seen); end
        repeat (31) @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        base_wr = wr_count;
        #1;
        total += 2;
        if (done !== 1'b0) begin bad++; $display("FAIL midrun_done got %b want 0", done); end
        if (mem_we !== 1'b0) begin bad++; $display("FAIL midrun_we got %b want 0", mem_we); end
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        repeat (300) @(negedge clk);
        total += 2;
        if (wr_count !== base_wr) begin bad++; $display("FAIL midrun_quiet got %0d writes want 0", wr_count - base_wr); end
        if (done !== 1'b0) begin bad++; $display("FAIL midrun_idle_done got %b want 0", done); end
        load_and_expect(32'h13579bdf, 16'd300, 16'd3000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2201, "fresh");
        total += 2;
        if (wr_count - base_wr !== 16) begin bad++; $display("FAIL fresh_writes got %0d want 16", wr_count - base_wr); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL fresh_pending got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_restart;
        int base_wr;
        load_and_expect(32'h0badf00d, 16'd200, 16'd4000);
        base_wr = wr_count;
        message_addr = 16'd200; output_addr = 16'd4000;
        start = 1'b1;
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL restart_clear got done=%b want 0", done); end
        repeat (4) @(negedge clk);
        start = 1'b0;
        wait_done(2201, "restart");
        repeat (200) @(negedge clk);
        total += 3;
        if (done !== 1'b1) begin bad++; $display("FAIL restart_hold got done=%b want 1", done); end
        if (wr_count - base_wr !== 16) begin bad++; $display("FAIL restart_writes got %0d want 16", wr_count - base_wr); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL restart_pending got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_param4;
        int cyc;
        set_header(32'h2468ace1);
        for (int i = 0; i < 19; i++) mem4[10 + i] = hdr[i];
        for (int n = 0; n < 4; n++) exp4_q.push_back({16'd500 + 16'(n), model_h0(32'(n))});
        msg4 = 16'd10; out4 = 16'd500;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cyc = 1;
        while (done4 !== 1'b1 && cyc < 900) begin
            @(negedge clk);
            cyc++;
        end
        repeat (20) @(negedge clk);
        total += 3;
        if (done4 !== 1'b1 || cyc > 617) begin bad++; $display("FAIL p4_latency got %0d cycles done=%b want within 617", cyc, done4); end
        if (wr4_count !== 4) begin bad++; $display("FAIL p4_writes got %0d want 4", wr4_count); end
        if (exp4_q.size() !== 0) begin bad++; $display("FAIL p4_pending got %0d want 0", exp4_q.size()); end
    endtask

    initial begin
        reset_n = 1'b1;
        start = 1'b0; start4 = 1'b0;
        message_addr = 16'h0; output_addr = 16'h0; msg4 = 16'h0; out4 = 16'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        for (int i = 0; i < 1024; i++) mem4[i] = 32'h0;
        test_model();
        test_reset();
        test_golden();
        test_alt_addr();
        test_reset_midrun();
        test_restart();
        test_param4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitcoin2.md
# bitcoin2

Bitcoin-style double-SHA-256 nonce search co-processor. On `start` it reads a 19-word block-header prefix from shared memory, hashes the 640-bit header once for each nonce 0..NUM_NONCES-1 using SHA-256 applied twice, and writes word H0 of each final digest back to memory. It sits behind a single-port 32-bit word memory and signals completion with `done`.

## Interface
- `NUM_NONCES`, default 16. Number of nonces tried (0..NUM_NONCES-1) and number of result words written.

- `clk`  in  1  Design clock.
- `reset_n`  in  1  Reset. Asynchronous, active-high: while it is 1 the block is held in reset. The port name is kept for codebase compatibility.
- `start`  in  1  Level start request. Sampled only in IDLE.
- `message_addr`  in  16  Word address of header word 0.
- `output_addr`  in  16  Word address of the result for nonce 0.
- `done`  out  1  High while the FSM is in DONE.
- `mem_clk`  out  1  Memory clock, driven as `clk` directly.
- `mem_we`  out  1  Write enable. 1 = write, 0 = read.
- `mem_addr`  out  16  Word address.
- `mem_write_data`  out  32  Write data.
- `mem_read_data`  in  32  Read data. Valid one cycle after the address is presented.

## Operation
- **States:** IDLE → READ → BLK1 → BLK2 → HASH2 → WRITE → (BLK2 for the next nonce, or DONE).
- **READ:** fetch words M[0..18] from `message_addr`+0..18 into internal registers.
- **Block-2 words:** W0..15 = M[16], M[17], M[18], nonce, 0x80000000, then zeros, then 640 (0x280) in word 15.
- **BLK1:** compress W = M[0..15] starting from the standard SHA-256 IV (6a09e667 … 5be0cd19). The result is the midstate, computed once per `start`.
- **BLK2:** compress the block-2 words starting from the midstate. The result is H[0..7].
- **HASH2:** compress the following block starting from the standard IV:
  - words 0..7 = H[0..7]
  - word 8 = 0x80000000
  - words 9..14 = 0
  - word 15 = 256
- **WRITE:** write the final digest word 0 to `output_addr`+nonce.
  - If nonce < NUM_NONCES-1: increment nonce and go to BLK2.
  - Otherwise go to DONE.
- **Compression engine:** a single engine, one round per clock.
  - Message schedule uses a 16-word sliding window: Wt = W[t-16] + σ0(W[t-15]) + W[t-7] + σ1(W[t-2]).
  - σ0 = ror7 ^ ror18 ^ shr3; σ1 = ror17 ^ ror19 ^ shr10.
  - Round uses standard Σ0/Σ1/Ch/Maj and the 64 K constants.
  - All adds are modulo 2^32.
- **Final add:** after round 63, one cycle adds a..h to the block's initial hash.
- **DONE:** `done`=1, no memory accesses. When `start`=1, clear `done` and go to READ, re-reading the addresses.
- Memory contents outside `output_addr`..`output_addr`+NUM_NONCES-1 are never written.

## Timing
- **Reset values:** `done`=0, `mem_we`=0, `mem_addr`=0, `mem_write_data`=0, FSM=IDLE, nonce=0.
- **Reads:** address issued in cycle k with `mem_we`=0; data captured at the clk edge ending cycle k+1. Reads are pipelined, so READ takes 20 cycles.
- **Writes:** `mem_we`=1 with address and data valid for exactly one cycle per result. Exactly NUM_NONCES write cycles occur per run.
- **Latency per compression:** 64 round cycles plus 1 final-add cycle.
- **Total latency:** start to `done` rise ≤ 20 + 65 + NUM_NONCES×(2×65 + 2) + 4 cycles, which is 2201 for 16 nonces.
- **Start:** `start` is ignored outside IDLE/DONE. Holding `start` high for several cycles launches only one run.
- **Reset mid-run:** asserting reset in any state aborts immediately to IDLE with reset values. No further writes occur.
- `message_addr`/`output_addr` are sampled when leaving IDLE/DONE and held internally for the run.

## Test plan
- **Golden run:**
  - Stimulus: header M[0]=0x01234567, M[i]=rotl1(M[i-1]) for i=1..18, so M[1]=0x02468ace; `message_addr`=0, `output_addr`=1000; pulse `start` for 2 cycles.
  - Required response: words 1000..1015 equal the software double-SHA-256 H0 for nonces 0..15; `done` rises within 2201 cycles.
- **Write discipline:** count `mem_we` cycles during the golden run → exactly 16, at addresses 1000..1015 in ascending order. Memory words 0..18 are unchanged.
- **Alternate seed and addresses:** seed 0xdeadbeef, `message_addr`=100, `output_addr`=2000 → matches the model and no writes occur outside 2000..2015.
- **Reset mid-run:** assert reset at round 30 of nonce 5, then release → `done`=0, `mem_we`=0, no further writes. A fresh `start` produces correct results for all 16 nonces.
- **Restart from DONE:** after `done`, hold `start` high for 5 cycles with a new seed → `done` clears, exactly one run executes, and the results match the new seed.
- **Parameter:** NUM_NONCES=4 → 4 result words written, and `done` asserts within 20+65+4×132+4 cycles.
